neuromorphic_wb_cmd_ctrl: RTL and testbench
===========================================

Name: neuromorphic_wb_cmd_ctrl

Overview:
- Parametrised Wishbone slave front-end for the neuromorphic crossbar array. Replaces fixed 32x32 command handling.
- Buffers packed program/read commands in a command FIFO and returns read results through a response FIFO.
- Adds status and control registers, bad-mode and sel error detection, flush, and a bounded read-stall timeout.
- Sits between the Caravel Wishbone bus and the array core handshake; single clock domain.

Parameters:
- BASE_ADDR, 32'h3000_0000, base of the register window.
- ROW_W, 5, row index width.
- COL_W, 5, column index width. DATA_W = 30-ROW_W-COL_W (default 20); ROW_W+COL_W must be at most 29.
- CMD_DEPTH, 32, command FIFO entries. Power of 2, 2..128.
- RSP_DEPTH, 32, response FIFO entries. Power of 2, 2..128.
- RSP_W, 32, response data width (at most 32).
- RD_TIMEOUT, 1024, maximum stall cycles for a data read when the response FIFO is empty.

Ports:
- wb_clk_i  in  1  Clock.
- wb_rst_n_i  in  1  Reset. Asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  Write enable.
- wbs_sel_i  in  4  Byte select.
- wbs_adr_i  in  32  Address.
- wbs_dat_i  in  32  Write data.
- wbs_dat_o  out  32  Read data.
- wbs_ack_o  out  1  Acknowledge.
- cmd_valid_o  out  1  Command available to core.
- cmd_ready_i  in  1  Core accepts command.
- cmd_mode_o  out  2  Command mode.
- cmd_row_o  out  ROW_W  Row index.
- cmd_col_o  out  COL_W  Column index.
- cmd_data_o  out  DATA_W  Program data.
- rsp_valid_i  in  1  Core result valid.
- rsp_ready_o  out  1  Response FIFO not full.
- rsp_data_i  in  RSP_W  Result data.
- irq_o  out  1  Level interrupt: response FIFO non-empty OR any sticky flag set.

Behaviour:
- Register map (offsets from BASE_ADDR):
  - 0x0C DATA. Write pushes a command. Read pops a response, zero-extended to 32 bits.
  - 0x10 STATUS, read-only.
  - 0x14 CTRL, write-only. Reads return 0.
- Other offsets, and addresses outside the window: ack, read data 0, writes ignored. The bus never hangs.
- Command word packing: {mode[31:30], row, col, data}, MSB to LSB.
- Mode encoding: 11 PROGRAM, 01 READ, 00 NOP, 10 reserved.
  - NOP and reserved: acked, not queued.
  - Reserved also sets sticky bad_mode.
- DATA write with sel!=4'hF: acked, dropped, sets sticky sel_err.
- STATUS bit fields:
  - [0] cmd_empty, [1] cmd_full, [2] rsp_empty, [3] rsp_full.
  - [4] bad_mode, [5] rd_timeout, [6] sel_err (sticky).
  - [15:8] cmd_count, [23:16] rsp_count. Remaining bits 0.
- CTRL bits:
  - bit0 flushes both FIFOs (counts to 0 next cycle).
  - bit1 clears all sticky flags.
  - Both may be set in the same write.
- Bus FSM states: IDLE, WR_WAIT, RD_WAIT, ACK.
  - IDLE: on cyc&stb, decode the access.
    - DATA write with cmd FIFO not full: push, go to ACK.
    - DATA write with cmd FIFO full: go to WR_WAIT.
    - DATA read with rsp FIFO non-empty: pop, latch data, go to ACK.
    - DATA read with rsp FIFO empty: go to RD_WAIT and clear the timeout counter.
    - All other accesses: go to ACK.
  - WR_WAIT: push as soon as a slot frees (including the same cycle the core pops), then go to ACK.
  - RD_WAIT: pop as soon as a response arrives, then go to ACK.
    - Counter reaching RD_TIMEOUT: ack with data 0, set rd_timeout.
  - ACK: wbs_ack_o high exactly 1 cycle, then IDLE. A new access is accepted no earlier than the next cycle.
  - cyc dropping in WR_WAIT or RD_WAIT: return to IDLE, no push, no pop, no flag.
- Latency with no stall: ack is asserted 1 cycle after the cycle stb is sampled. wbs_dat_o is valid while ack is high, 0 otherwise.
- Core side: cmd_* is the FIFO head, valid whenever the FIFO is non-empty. Transfer happens on valid&ready. Response pushes on rsp_valid_i&rsp_ready_o.
- FIFOs:
  - Simultaneous push and pop are both performed; count unchanged, including when full.
  - Push when full is impossible by construction.
  - Pointers wrap modulo DEPTH.
- Flush has priority over push and pop in the same cycle.
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0, cmd_valid_o=0, cmd_* outputs 0.
  - rsp_ready_o=1, irq_o=0.
  - FIFOs empty, flags 0, FSM IDLE.
  - Reset mid-transaction aborts without ack.

Decomposition:
- Package neuromorphic_wb_pkg holds:
  - Register offsets (DATA, STATUS, CTRL).
  - Mode encodings.
  - STATUS bit positions.
  - FSM state encoding.
- Sub-module nm_sync_fifo (WIDTH, DEPTH): count, full, empty, flush. Instantiated twice.

Test Plan:
- Reset, then read STATUS -> 32'h0000_0005. irq_o=0, rsp_ready_o=1.
- Write DATA = {11, row 1, col 1, 20'h000FF} with cmd_ready_i=0 -> cmd_valid_o=1, cmd_row_o=1, cmd_col_o=1, cmd_data_o=20'hFF. STATUS[15:8]=1.
- 33 DATA writes with cmd_ready_i=0 -> writes 1..32 ack in 2 cycles each. Write 33 stalls until cmd_ready_i pulses once, then acks. cmd_full=1 at end.
- Core pushes rsp_data_i=32'h1 -> irq_o=1. DATA read returns 32'h0000_0001. STATUS rsp_empty=1 afterwards.
- DATA read with rsp FIFO empty and RD_TIMEOUT=16 -> ack after 16 stall cycles with 0. STATUS[5]=1. CTRL write 32'h2 clears it.
- Write mode 10, then sel=4'h3 write, then CTRL=1 with 3 commands queued -> STATUS[4]=1 and [6]=1. Next cycle cmd_count=0, cmd_valid_o=0.

Source files
------------

// File: rtl/neuromorphic_wb_pkg.sv
// Shared definitions for the crossbar Wishbone command front-end:
// register offsets, command modes, STATUS layout and bus FSM encoding.
package neuromorphic_wb_pkg;

   localparam logic [7:0] OFS_DATA   = 8'h0C;
   localparam logic [7:0] OFS_STATUS = 8'h10;
   localparam logic [7:0] OFS_CTRL   = 8'h14;

   localparam logic [1:0] MODE_NOP  = 2'b00;
   localparam logic [1:0] MODE_READ = 2'b01;
   localparam logic [1:0] MODE_RSVD = 2'b10;
   localparam logic [1:0] MODE_PROG = 2'b11;

   localparam int ST_CMD_EMPTY = 0;
   localparam int ST_CMD_FULL  = 1;
   localparam int ST_RSP_EMPTY = 2;
   localparam int ST_RSP_FULL  = 3;
   localparam int ST_BAD_MODE  = 4;
   localparam int ST_RD_TMO    = 5;
   localparam int ST_SEL_ERR   = 6;
   localparam int ST_CMD_CNT   = 8;
   localparam int ST_RSP_CNT   = 16;

   typedef enum logic [1:0] {
      BUS_IDLE    = 2'd0,
      BUS_WR_WAIT = 2'd1,
      BUS_RD_WAIT = 2'd2,
      BUS_ACK     = 2'd3
   } bus_state_e;

endpackage

// File: rtl/nm_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush.
// Head word reads as zero while empty so downstream outputs idle at 0.
module nm_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n_i,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_en;
   logic             pop_en;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_en  = pop && !empty;
   // a full FIFO still accepts a word when a slot is freed in the same cycle
   assign push_en = push && (!full || pop_en);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push_en, pop_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push_en && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/neuromorphic_wb_cmd_ctrl.sv
// Wishbone slave front-end for the crossbar array: queues packed commands
// for the core, returns read results, exposes STATUS/CTRL registers.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   BUS_IDLE    | waiting for cyc&stb, decodes and services the access
//   BUS_WR_WAIT | DATA write parked until the command FIFO has a slot
//   BUS_RD_WAIT | DATA read parked until a response arrives or timer expires
//   BUS_ACK     | one-cycle acknowledge, read data presented
module neuromorphic_wb_cmd_ctrl
   import neuromorphic_wb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          ROW_W      = 5,
   parameter int          COL_W      = 5,
   parameter int          CMD_DEPTH  = 32,
   parameter int          RSP_DEPTH  = 32,
   parameter int          RSP_W      = 32,
   parameter int          RD_TIMEOUT = 1024,
   localparam int         DATA_W     = 30 - ROW_W - COL_W
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic [31:0]       wbs_dat_o,
   output logic              wbs_ack_o,
   output logic              cmd_valid_o,
   input  logic              cmd_ready_i,
   output logic [1:0]        cmd_mode_o,
   output logic [ROW_W-1:0]  cmd_row_o,
   output logic [COL_W-1:0]  cmd_col_o,
   output logic [DATA_W-1:0] cmd_data_o,
   input  logic              rsp_valid_i,
   output logic              rsp_ready_o,
   input  logic [RSP_W-1:0]  rsp_data_i,
   output logic              irq_o
);

   localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
   localparam int RSP_CW = $clog2(RSP_DEPTH) + 1;
   localparam int TW     = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

   bus_state_e        state_q, state_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic              bad_mode_q, rd_tmo_q, sel_err_q;

   logic [31:0]       cmd_head;
   logic [CMD_CW-1:0] cmd_count;
   logic              cmd_full, cmd_empty, cmd_push, cmd_pop;
   logic [RSP_W-1:0]  rsp_head;
   logic [RSP_CW-1:0] rsp_count;
   logic              rsp_full, rsp_empty, rsp_pop;

   logic              flush, clr_flags, set_bad, set_sel, set_tmo;
   logic [31:0]       ofs, status_word, rsp_word;
   logic              in_win, hit_data, hit_status, hit_ctrl, bus_req;
   logic [1:0]        wr_mode;

   nm_sync_fifo #(.WIDTH(32), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_n_i (wb_rst_n_i),
      .flush      (flush),
      .push       (cmd_push),
      .din        (wbs_dat_i),
      .pop        (cmd_pop),
      .dout       (cmd_head),
      .count      (cmd_count),
      .full       (cmd_full),
      .empty      (cmd_empty)
   );

   nm_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_n_i (wb_rst_n_i),
      .flush      (flush),
      .push       (rsp_valid_i && rsp_ready_o),
      .din        (rsp_data_i),
      .pop        (rsp_pop),
      .dout       (rsp_head),
      .count      (rsp_count),
      .full       (rsp_full),
      .empty      (rsp_empty)
   );

   assign cmd_valid_o = !cmd_empty;
   assign cmd_pop     = cmd_valid_o && cmd_ready_i;
   assign cmd_mode_o  = cmd_head[31:30];
   assign cmd_row_o   = cmd_head[29 -: ROW_W];
   assign cmd_col_o   = cmd_head[29-ROW_W -: COL_W];
   assign cmd_data_o  = cmd_head[DATA_W-1:0];
   assign rsp_ready_o = !rsp_full;
   assign irq_o       = !rsp_empty || bad_mode_q || rd_tmo_q || sel_err_q;

   assign wbs_ack_o   = (state_q == BUS_ACK);
   assign wbs_dat_o   = wbs_ack_o ? rdata_q : '0;

   assign ofs         = wbs_adr_i - BASE_ADDR;
   assign in_win      = (ofs[31:8] == '0);
   assign hit_data    = in_win && (ofs[7:0] == OFS_DATA);
   assign hit_status  = in_win && (ofs[7:0] == OFS_STATUS);
   assign hit_ctrl    = in_win && (ofs[7:0] == OFS_CTRL);
   assign bus_req     = wbs_cyc_i && wbs_stb_i;
   assign wr_mode     = wbs_dat_i[31:30];
   assign rsp_word    = 32'(rsp_head);

   always_comb begin
      status_word               = '0;
      status_word[ST_CMD_EMPTY] = cmd_empty;
      status_word[ST_CMD_FULL]  = cmd_full;
      status_word[ST_RSP_EMPTY] = rsp_empty;
      status_word[ST_RSP_FULL]  = rsp_full;
      status_word[ST_BAD_MODE]  = bad_mode_q;
      status_word[ST_RD_TMO]    = rd_tmo_q;
      status_word[ST_SEL_ERR]   = sel_err_q;
      status_word[ST_CMD_CNT +: 8] = 8'(cmd_count);
      status_word[ST_RSP_CNT +: 8] = 8'(rsp_count);
   end

   always_comb begin
      state_d   = state_q;
      rdata_d   = rdata_q;
      tmr_d     = tmr_q;
      cmd_push  = 1'b0;
      rsp_pop   = 1'b0;
      flush     = 1'b0;
      clr_flags = 1'b0;
      set_bad   = 1'b0;
      set_sel   = 1'b0;
      set_tmo   = 1'b0;
      unique case (state_q)
         BUS_IDLE: begin
            if (bus_req) begin
               state_d = BUS_ACK;
               rdata_d = '0;
               if (hit_data && wbs_we_i) begin
                  if (wbs_sel_i != 4'hF) begin
                     set_sel = 1'b1;
                  end else begin
                     unique case (wr_mode)
                        MODE_PROG, MODE_READ: begin
                           if (cmd_full) state_d = BUS_WR_WAIT;
                           else          cmd_push = 1'b1;
                        end
                        MODE_RSVD: set_bad = 1'b1;
                        default:   ;
                     endcase
                  end
               end else if (hit_data) begin
                  if (!rsp_empty) begin
                     rsp_pop = 1'b1;
                     rdata_d = rsp_word;
                  end else begin
                     state_d = BUS_RD_WAIT;
                     tmr_d   = TW'(RD_TIMEOUT - 1);
                  end
               end else if (hit_status && !wbs_we_i) begin
                  rdata_d = status_word;
               end else if (hit_ctrl && wbs_we_i) begin
                  flush     = wbs_dat_i[0];
                  clr_flags = wbs_dat_i[1];
               end
            end
         end
         BUS_WR_WAIT: begin
            if (!wbs_cyc_i) begin
               state_d = BUS_IDLE;
            end else if (!cmd_full || cmd_pop) begin
               cmd_push = 1'b1;
               state_d  = BUS_ACK;
            end
         end
         BUS_RD_WAIT: begin
            if (!wbs_cyc_i) begin
               state_d = BUS_IDLE;
            end else if (!rsp_empty) begin
               rsp_pop = 1'b1;
               rdata_d = rsp_word;
               state_d = BUS_ACK;
            end else if (tmr_q == '0) begin
               set_tmo = 1'b1;
               rdata_d = '0;
               state_d = BUS_ACK;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         BUS_ACK: state_d = BUS_IDLE;
         default: state_d = BUS_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q    <= BUS_IDLE;
         rdata_q    <= '0;
         tmr_q      <= '0;
         bad_mode_q <= 1'b0;
         rd_tmo_q   <= 1'b0;
         sel_err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         tmr_q   <= tmr_d;
         if (clr_flags) begin
            bad_mode_q <= 1'b0;
            rd_tmo_q   <= 1'b0;
            sel_err_q  <= 1'b0;
         end else begin
            bad_mode_q <= bad_mode_q || set_bad;
            rd_tmo_q   <= rd_tmo_q || set_tmo;
            sel_err_q  <= sel_err_q || set_sel;
         end
      end
   end

endmodule

// File: tb/tb_neuromorphic_wb_cmd_ctrl.sv
// Scoreboard bench for the crossbar Wishbone front-end: bus tasks queue the
// expected read data and ack latency, a negedge monitor checks each ack.
module tb_neuromorphic_wb_cmd_ctrl;

   localparam int TMO = 16;
   localparam logic [31:0] BASE  = 32'h3000_0000;
   localparam logic [31:0] A_DAT = BASE + 32'h0C;
   localparam logic [31:0] A_STS = BASE + 32'h10;
   localparam logic [31:0] A_CTL = BASE + 32'h14;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_n_i;
   logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
   logic        wbs_ack_o;
   logic        cmd_valid_o, cmd_ready_i;
   logic [1:0]  cmd_mode_o;
   logic [4:0]  cmd_row_o, cmd_col_o;
   logic [19:0] cmd_data_o;
   logic        rsp_valid_i, rsp_ready_o;
   logic [31:0] rsp_data_i;
   logic        irq_o;

   neuromorphic_wb_cmd_ctrl #(.RD_TIMEOUT(TMO)) dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_n_i  (wb_rst_n_i),
      .wbs_stb_i   (wbs_stb_i),
      .wbs_cyc_i   (wbs_cyc_i),
      .wbs_we_i    (wbs_we_i),
      .wbs_sel_i   (wbs_sel_i),
      .wbs_adr_i   (wbs_adr_i),
      .wbs_dat_i   (wbs_dat_i),
      .wbs_dat_o   (wbs_dat_o),
      .wbs_ack_o   (wbs_ack_o),
      .cmd_valid_o (cmd_valid_o),
      .cmd_ready_i (cmd_ready_i),
      .cmd_mode_o  (cmd_mode_o),
      .cmd_row_o   (cmd_row_o),
      .cmd_col_o   (cmd_col_o),
      .cmd_data_o  (cmd_data_o),
      .rsp_valid_i (rsp_valid_i),
      .rsp_ready_o (rsp_ready_o),
      .rsp_data_i  (rsp_data_i),
      .irq_o       (irq_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   typedef struct {
      string       nm;
      logic [31:0] dat;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   wait_cnt = 0;

   always @(negedge wb_clk_i) begin
      if (wbs_ack_o) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: got ack with dat=%h, want no ack", wbs_dat_o);
         end else begin
            mon_e = sb_q.pop_front();
            total++;
            if (wbs_dat_o !== mon_e.dat) begin
               bad++;
               $display("FAIL %s dat: got %h want %h", mon_e.nm, wbs_dat_o, mon_e.dat);
            end
            if (mon_e.lat >= 0) begin
               total++;
               if (wait_cnt != mon_e.lat) begin
                  bad++;
                  $display("FAIL %s latency: got %0d want %0d", mon_e.nm, wait_cnt, mon_e.lat);
               end
            end
         end
         wait_cnt = 0;
      end else if (wbs_cyc_i && wbs_stb_i) begin
         wait_cnt++;
      end else begin
         wait_cnt = 0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic bus(input string nm, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input logic [31:0] exp_dat, input int lat);
      exp_t e;
      bit   got = 1'b0;
      e.nm = nm; e.dat = exp_dat; e.lat = lat;
      sb_q.push_back(e);
      @(posedge wb_clk_i); #1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
      for (int i = 0; i < 200; i++) begin
         @(negedge wb_clk_i);
         if (wbs_ack_o) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL %s: got no ack within 200 cycles, want ack", nm);
         void'(sb_q.pop_back());
      end
      @(posedge wb_clk_i); #1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
   endtask

   task automatic core_rsp(input logic [31:0] d);
      @(posedge wb_clk_i); #1;
      rsp_valid_i = 1'b1; rsp_data_i = d;
      @(posedge wb_clk_i); #1;
      rsp_valid_i = 1'b0;
   endtask

   function automatic logic [31:0] prog_word(input int i);
      logic [4:0] r;
      r = 5'(i);
      return {2'b11, r, r ^ 5'h1F, 20'(i)};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      wb_rst_n_i  = 1'b0;
      wbs_cyc_i   = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i   = 4'h0; wbs_adr_i = '0;   wbs_dat_i = '0;
      cmd_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_data_i = '0;
      repeat (3) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      chk("rst_ack",       32'(wbs_ack_o),   32'd0);
      chk("rst_dat",       wbs_dat_o,        32'd0);
      chk("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
      chk("rst_rsp_ready", 32'(rsp_ready_o), 32'd1);
      chk("rst_irq",       32'(irq_o),       32'd0);
      @(posedge wb_clk_i); #1;
      wb_rst_n_i = 1'b1;

      bus("status_reset", 1'b0, A_STS, '0, 4'hF, 32'h0000_0005, 1);

      // single program command, head visible to the core
      bus("wr_first", 1'b1, A_DAT, 32'hC210_00FF, 4'hF, 32'h0, 1);
      @(negedge wb_clk_i);
      chk("head_valid", 32'(cmd_valid_o), 32'd1);
      chk("head_mode",  32'(cmd_mode_o),  32'd3);
      chk("head_row",   32'(cmd_row_o),   32'd1);
      chk("head_col",   32'(cmd_col_o),   32'd1);
      chk("head_data",  32'(cmd_data_o),  32'h000FF);
      bus("status_one", 1'b0, A_STS, '0, 4'hF, 32'h0000_0104, 1);
      bus("flush_a", 1'b1, A_CTL, 32'h1, 4'hF, 32'h0, 1);
      bus("status_flushed", 1'b0, A_STS, '0, 4'hF, 32'h0000_0005, 1);

      // fill the command FIFO, the 33rd write parks until the core takes one
      for (int i = 1; i <= 32; i++)
         bus("wr_fill", 1'b1, A_DAT, prog_word(i), 4'hF, 32'h0, 1);
      fork
         bus("wr_stall", 1'b1, A_DAT, prog_word(33), 4'hF, 32'h0, 6);
         begin
            repeat (6) @(posedge wb_clk_i);
            #1 cmd_ready_i = 1'b1;
            @(posedge wb_clk_i);
            #1 cmd_ready_i = 1'b0;
         end
      join
      bus("status_full", 1'b0, A_STS, '0, 4'hF, 32'h0000_2006, 1);
      @(negedge wb_clk_i);
      chk("head_after_pop_row",  32'(cmd_row_o),  32'd2);
      chk("head_after_pop_col",  32'(cmd_col_o),  32'd29);
      chk("head_after_pop_data", 32'(cmd_data_o), 32'd2);
      bus("flush_b", 1'b1, A_CTL, 32'h1, 4'hF, 32'h0, 1);
      @(negedge wb_clk_i);
      chk("flush_cmd_valid", 32'(cmd_valid_o), 32'd0);

      // response path
      core_rsp(32'h0000_0001);
      @(negedge wb_clk_i);
      chk("irq_rsp", 32'(irq_o), 32'd1);
      bus("rd_one", 1'b0, A_DAT, '0, 4'hF, 32'h0000_0001, 1);
      bus("status_rsp_empty", 1'b0, A_STS, '0, 4'hF, 32'h0000_0005, 1);
      core_rsp(32'hA5A5_0001);
      core_rsp(32'h0000_BEEF);
      bus("status_rsp_two", 1'b0, A_STS, '0, 4'hF, 32'h0002_0001, 1);
      bus("rd_order_0", 1'b0, A_DAT, '0, 4'hF, 32'hA5A5_0001, 1);
      bus("rd_order_1", 1'b0, A_DAT, '0, 4'hF, 32'h0000_BEEF, 1);
      fork
         bus("rd_stall", 1'b0, A_DAT, '0, 4'hF, 32'h1357_9BDF, 5);
         begin
            repeat (4) @(posedge wb_clk_i);
            #1 rsp_valid_i = 1'b1; rsp_data_i = 32'h1357_9BDF;
            @(posedge wb_clk_i);
            #1 rsp_valid_i = 1'b0;
         end
      join

      // read timeout and sticky clear
      bus("rd_timeout", 1'b0, A_DAT, '0, 4'hF, 32'h0, TMO + 1);
      bus("status_tmo", 1'b0, A_STS, '0, 4'hF, 32'h0000_0025, 1);
      @(negedge wb_clk_i);
      chk("irq_tmo", 32'(irq_o), 32'd1);
      bus("ctrl_clr", 1'b1, A_CTL, 32'h2, 4'hF, 32'h0, 1);
      bus("status_clr", 1'b0, A_STS, '0, 4'hF, 32'h0000_0005, 1);
      @(negedge wb_clk_i);
      chk("irq_clr", 32'(irq_o), 32'd0);

      // unmapped offsets and out-of-window addresses
      bus("rd_ctrl", 1'b0, A_CTL, '0, 4'hF, 32'h0, 1);
      bus("rd_outside", 1'b0, 32'h4000_000C, '0, 4'hF, 32'h0, 1);
      bus("wr_offset0", 1'b1, BASE, prog_word(7), 4'hF, 32'h0, 1);
      bus("wr_outside", 1'b1, 32'h4000_000C, prog_word(7), 4'hF, 32'h0, 1);

      // cyc dropped while a read is parked: no ack, no flag
      @(posedge wb_clk_i); #1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_DAT;
      repeat (4) @(posedge wb_clk_i);
      #1 wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      repeat (3) @(posedge wb_clk_i);
      bus("status_abort", 1'b0, A_STS, '0, 4'hF, 32'h0000_0005, 1);

      // error flags, NOP drop, flush with commands queued
      bus("wr_rsvd", 1'b1, A_DAT, 32'h8000_0000, 4'hF, 32'h0, 1);
      bus("wr_sel",  1'b1, A_DAT, prog_word(9), 4'h3, 32'h0, 1);
      bus("wr_nop",  1'b1, A_DAT, 32'h0000_1234, 4'hF, 32'h0, 1);
      bus("wr_q0", 1'b1, A_DAT, prog_word(3), 4'hF, 32'h0, 1);
      bus("wr_q1", 1'b1, A_DAT, 32'h4000_0000 | prog_word(4), 4'hF, 32'h0, 1);
      bus("wr_q2", 1'b1, A_DAT, prog_word(5), 4'hF, 32'h0, 1);
      bus("status_err", 1'b0, A_STS, '0, 4'hF, 32'h0000_0354, 1);
      bus("flush_c", 1'b1, A_CTL, 32'h1, 4'hF, 32'h0, 1);
      @(negedge wb_clk_i);
      chk("flush_c_valid", 32'(cmd_valid_o), 32'd0);
      chk("irq_flags",     32'(irq_o),       32'd1);
      bus("status_final", 1'b0, A_STS, '0, 4'hF, 32'h0000_0055, 1);

      repeat (3) @(posedge wb_clk_i);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
